retire_unit: RTL and testbench
==============================

Name: retire_unit

Overview:
- Parametrised commit stage between execute and the architectural state: register file, PC redirect and data memory.
- Per-instruction tag check against the current epoch; stale-tag results are discarded.
- Accepted jumps advance the epoch.
- Committed stores are queued in a SB_DEPTH-entry store buffer and drained to memory over a valid/ready handshake.
- All outputs are registered and always driven (no tri-state).

Parameters:
- XLEN, 32, datapath/address width.
- TAG_W, 4, epoch tag width; tag wraps modulo 2^TAG_W.
- SB_DEPTH, 4, store buffer entries; power of two, >=2.
- REG_AW, 5, register file address width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_valid  in  1  execute result valid
- o_ready  out  1  retire can accept
- i_result0  in  XLEN  ALU/load result; store data
- i_result1  in  XLEN  jump target; store address
- i_tag  in  TAG_W  epoch tag of instruction
- i_wr_en  in  1  instruction writes rd
- i_rd  in  REG_AW  destination register
- i_jump  in  1  instruction redirects PC
- i_write  in  1  instruction is a store
- i_size  in  2  store size (0=B,1=H,2=W)
- o_reg_wr_en  out  1  register write strobe
- o_rd  out  REG_AW  register write address
- o_wr_data  out  XLEN  register write data
- o_jump  out  1  one-cycle redirect pulse
- o_new_pc  out  XLEN  redirect target
- o_mem_valid  out  1  store request valid
- i_mem_ready  in  1  memory accepts store
- o_mem_addr  out  XLEN  store address
- o_mem_data  out  XLEN  store data
- o_mem_size  out  2  store size
- o_sb_empty  out  1  store buffer empty (fence support)
- o_sb_count  out  clog2(SB_DEPTH)+1  store buffer occupancy

Behaviour:
- Reset (async, i_rstn=0):
  - curr_tag=0; store buffer emptied (pointers and count 0).
  - All outputs 0, except o_sb_empty=1 and o_ready=1.
  - A reset mid-drain drops pending stores and deasserts o_mem_valid immediately.
- Accept: fire = i_valid & o_ready. o_ready = !sb_full, registered from next-state count.
- Kill: killed = (i_tag != curr_tag), evaluated combinationally at fire.
  - A killed instruction is consumed and produces no side effect.
- Register writeback: fire & !killed & i_wr_en -> next cycle o_reg_wr_en=1, o_rd=i_rd, o_wr_data=i_result0.
  - Otherwise o_reg_wr_en=0, and o_rd/o_wr_data are held.
  - Latency 1.
- Jump: fire & !killed & i_jump -> next cycle o_jump=1 for exactly one cycle and o_new_pc=i_result1.
  - curr_tag increments on the same edge; wrap from 2^TAG_W-1 to 0.
  - The instruction in the following cycle carrying the old tag is killed.
  - o_new_pc holds its value after the pulse.
- Store push: fire & !killed & i_write -> write {i_result1, i_result0, i_size} at the tail; count+1.
  - A killed store never enters the buffer.
- Store drain: o_mem_valid = !empty; o_mem_addr/o_mem_data/o_mem_size come from the head entry.
  - Pop on o_mem_valid & i_mem_ready.
  - Head fields stay stable while o_mem_valid & !i_mem_ready.
  - A pushed store appears at the head 1 cycle after the push if the buffer was empty.
  - Store fields read as 0 when the buffer is empty.
- Simultaneous push and pop: allowed when not full; count unchanged; pointers both advance.
- Full: o_ready=0 in the cycle after count reaches SB_DEPTH. It returns to 1 in the cycle after a pop.
  - Non-store instructions also stall (in-order commit).
- Combined op: one instruction may assert i_wr_en and i_jump together (JAL/JALR); both effects occur in the same cycle.
  - i_write with i_jump is illegal; behaviour is undefined and is flagged by assertion in simulation.

Optional Feature:
- Macro RETIRE_PERF_CNT_EN. When defined, the block adds:
  - 32-bit counters o_retired_cnt (fire & !killed) and o_killed_cnt (fire & killed), plus a 32-bit counter o_sb_stall_cnt (i_valid & !o_ready).
  - All three reset to 0, wrap on overflow, and are read as outputs.
- Without the macro, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset release, fire tag=0 wr_en rd=5 result0=0x1234 -> next cycle o_reg_wr_en=1, o_rd=5, o_wr_data=0x1234. A tag=3 instruction -> no write.
- Jump tag=0 result1=0x80 then ALU tag=0 back-to-back -> o_jump pulse with o_new_pc=0x80; second instruction killed; curr_tag=1; a tag=1 instruction retires.
- 16 consecutive non-killed jumps (TAG_W=4) -> tag wraps 15->0; a tag=0 instruction after the 16th jump retires.
- 4 stores (addr 0x100..0x10C, data 0xA0..0xA3) with i_mem_ready=0 -> o_ready=0 after the 4th and a 5th store stalls. Raise i_mem_ready -> in-order drain 0x100..0x10C, o_ready back to 1, o_sb_empty=1 at the end.
- Store push with simultaneous pop at count=2 -> count remains 2; head data unchanged while i_mem_ready=0.
- Assert i_rstn=0 with 3 stores pending -> o_mem_valid=0, o_sb_count=0 immediately; curr_tag=0.

Source files
------------

// File: rtl/retire_unit_if.sv
// Execute-to-retire and retire-to-memory signal bundle for retire_unit.
// slave modport is the retire stage; master is the execute/memory side.
interface retire_unit_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned REG_AW   = 5
);
  localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

  logic              i_valid;
  logic              o_ready;
  logic [XLEN-1:0]   i_result0;
  logic [XLEN-1:0]   i_result1;
  logic [TAG_W-1:0]  i_tag;
  logic              i_wr_en;
  logic [REG_AW-1:0] i_rd;
  logic              i_jump;
  logic              i_write;
  logic [1:0]        i_size;

  logic              o_reg_wr_en;
  logic [REG_AW-1:0] o_rd;
  logic [XLEN-1:0]   o_wr_data;
  logic              o_jump;
  logic [XLEN-1:0]   o_new_pc;

  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [XLEN-1:0]   o_mem_addr;
  logic [XLEN-1:0]   o_mem_data;
  logic [1:0]        o_mem_size;
  logic              o_sb_empty;
  logic [CW-1:0]     o_sb_count;

  modport slave (
    input  i_valid, i_result0, i_result1, i_tag, i_wr_en, i_rd, i_jump, i_write, i_size,
    input  i_mem_ready,
    output o_ready, o_reg_wr_en, o_rd, o_wr_data, o_jump, o_new_pc,
    output o_mem_valid, o_mem_addr, o_mem_data, o_mem_size, o_sb_empty, o_sb_count
  );

  modport master (
    output i_valid, i_result0, i_result1, i_tag, i_wr_en, i_rd, i_jump, i_write, i_size,
    output i_mem_ready,
    input  o_ready, o_reg_wr_en, o_rd, o_wr_data, o_jump, o_new_pc,
    input  o_mem_valid, o_mem_addr, o_mem_data, o_mem_size, o_sb_empty, o_sb_count
  );
endinterface

// File: rtl/retire_unit.sv
// Commit stage: epoch tag check, register writeback, PC redirect and a store buffer
// drained to memory. Define RETIRE_PERF_CNT_EN to add retired/killed/stall counters.
module retire_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned REG_AW   = 5
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  retire_unit_if.slave bus
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]  o_retired_cnt,
  output logic [31:0]  o_killed_cnt,
  output logic [31:0]  o_sb_stall_cnt
`endif
);
  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      size;
  } sb_entry_t;

  sb_entry_t         sb_mem [SB_DEPTH];
  sb_entry_t         new_entry, head_d, head_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              ready_q, mem_valid_q, empty_q;
  logic              reg_wr_en_q, jump_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   wr_data_q, new_pc_q;
  logic              fire, killed, commit, push, pop;

  always_comb begin
    fire      = bus.i_valid & ready_q;
    killed    = (bus.i_tag != tag_q);
    commit    = fire & ~killed;
    push      = commit & bus.i_write;
    pop       = mem_valid_q & bus.i_mem_ready;
    new_entry = '{addr: bus.i_result1, data: bus.i_result0, size: bus.i_size};

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // Head is registered, so bypass the entry being written when it becomes the head.
    head_d = '0;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = new_entry;
      else                                head_d = sb_mem[rd_ptr_d];
    end

    tag_d = tag_q;
    if (commit && bus.i_jump) tag_d = tag_q + TAG_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (push) sb_mem[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_q       <= '0;
      head_q      <= '0;
      ready_q     <= 1'b1;
      mem_valid_q <= 1'b0;
      empty_q     <= 1'b1;
      reg_wr_en_q <= 1'b0;
      rd_q        <= '0;
      wr_data_q   <= '0;
      jump_q      <= 1'b0;
      new_pc_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      head_q      <= head_d;
      ready_q     <= (count_d != CW'(SB_DEPTH));
      mem_valid_q <= (count_d != '0);
      empty_q     <= (count_d == '0);
      reg_wr_en_q <= commit & bus.i_wr_en;
      jump_q      <= commit & bus.i_jump;
      if (commit && bus.i_wr_en) begin
        rd_q      <= bus.i_rd;
        wr_data_q <= bus.i_result0;
      end
      if (commit && bus.i_jump) new_pc_q <= bus.i_result1;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_reg_wr_en = reg_wr_en_q;
  assign bus.o_rd        = rd_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_jump      = jump_q;
  assign bus.o_new_pc    = new_pc_q;
  assign bus.o_mem_valid = mem_valid_q;
  assign bus.o_mem_addr  = head_q.addr;
  assign bus.o_mem_data  = head_q.data;
  assign bus.o_mem_size  = head_q.size;
  assign bus.o_sb_empty  = empty_q;
  assign bus.o_sb_count  = count_q;

`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] retired_cnt_q, killed_cnt_q, stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      retired_cnt_q <= '0;
      killed_cnt_q  <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (commit)                   retired_cnt_q <= retired_cnt_q + 32'd1;
      if (fire && killed)           killed_cnt_q  <= killed_cnt_q + 32'd1;
      if (bus.i_valid && !ready_q)  stall_cnt_q   <= stall_cnt_q + 32'd1;
    end
  end

  assign o_retired_cnt  = retired_cnt_q;
  assign o_killed_cnt   = killed_cnt_q;
  assign o_sb_stall_cnt = stall_cnt_q;
`endif

  // A store that also redirects has no defined commit order.
  illegal_store_jump: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(fire && !killed && bus.i_write && bus.i_jump));

endmodule

// File: tb/tb_retire_unit.sv
// Table-driven bench for retire_unit with register-write and store-drain scoreboards.
module tb_retire_unit;
  localparam int unsigned XLEN = 32, TAG_W = 4, SB_DEPTH = 4, REG_AW = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  retire_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W), .SB_DEPTH(SB_DEPTH), .REG_AW(REG_AW)) bus ();

`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] retired_cnt, killed_cnt, stall_cnt;
`endif

  retire_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .SB_DEPTH(SB_DEPTH), .REG_AW(REG_AW)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
`ifdef RETIRE_PERF_CNT_EN
    ,
    .o_retired_cnt  (retired_cnt),
    .o_killed_cnt   (killed_cnt),
    .o_sb_stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [3:0]  tag;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        jump;
    logic        write;
    logic [1:0]  size;
    logic        exp_wr;
    logic        exp_jump;
    logic        exp_push;
  } vec_t;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } rw_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; logic [1:0] s; } st_t;

  vec_t        tbl[$];
  rw_t         rq[$];
  st_t         sq[$];
  int          total = 0;
  int          bad = 0;
  int          cnt_m = 0;
  logic [31:0] pc_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vl, input int tag, input logic wr, input int rd,
                              input logic [31:0] r0, input logic [31:0] r1, input logic jmp,
                              input logic wrt, input int sz, input logic ew, input logic ej,
                              input logic ep);
    vec_t v;
    v.valid = vl;   v.tag = 4'(tag);  v.wr_en = wr;  v.rd = 5'(rd);
    v.r0 = r0;      v.r1 = r1;        v.jump = jmp;  v.write = wrt;
    v.size = 2'(sz); v.exp_wr = ew;   v.exp_jump = ej; v.exp_push = ep;
    return v;
  endfunction

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic tick(input logic exp_wr, input logic exp_jump, input logic exp_push);
    logic pop;
    rw_t  e;
    pop = 1'b0;
    if (bus.o_mem_valid) begin
      if (sq.size() == 0) chk("mem_valid_unexpected", 1, 0);
      else begin
        chk("mem_addr", bus.o_mem_addr, sq[0].a);
        chk("mem_data", bus.o_mem_data, sq[0].d);
        chk("mem_size", bus.o_mem_size, sq[0].s);
        if (bus.i_mem_ready) begin
          void'(sq.pop_front());
          pop = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cnt_m = cnt_m + (exp_push ? 1 : 0) - (pop ? 1 : 0);
    chk("reg_wr_en", bus.o_reg_wr_en, exp_wr);
    if (exp_wr && bus.o_reg_wr_en && rq.size() != 0) begin
      e = rq.pop_front();
      chk("rd", bus.o_rd, e.rd);
      chk("wr_data", bus.o_wr_data, e.data);
    end
    chk("jump", bus.o_jump, exp_jump);
    chk("new_pc", bus.o_new_pc, pc_m);
    chk("sb_count", bus.o_sb_count, cnt_m);
    chk("sb_empty", bus.o_sb_empty, cnt_m == 0);
    chk("mem_valid", bus.o_mem_valid, cnt_m != 0);
    chk("ready", bus.o_ready, cnt_m != SB_DEPTH);
  endtask

  task automatic apply(input vec_t v);
    bus.i_valid   = v.valid;
    bus.i_tag     = v.tag;
    bus.i_wr_en   = v.wr_en;
    bus.i_rd      = v.rd;
    bus.i_result0 = v.r0;
    bus.i_result1 = v.r1;
    bus.i_jump    = v.jump;
    bus.i_write   = v.write;
    bus.i_size    = v.size;
    if (v.exp_wr)   rq.push_back('{rd: v.rd, data: v.r0});
    if (v.exp_jump) pc_m = v.r1;
    if (v.exp_push) sq.push_back('{a: v.r1, d: v.r0, s: v.size});
    tick(v.exp_wr, v.exp_jump, v.exp_push);
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 0; bus.i_tag = '0; bus.i_wr_en = 0; bus.i_rd = '0;
    bus.i_result0 = '0; bus.i_result1 = '0; bus.i_jump = 0; bus.i_write = 0;
    bus.i_size = '0; bus.i_mem_ready = 0;

    repeat (2) @(negedge clk);
    chk("rst_reg_wr_en", bus.o_reg_wr_en, 0);
    chk("rst_rd", bus.o_rd, 0);
    chk("rst_wr_data", bus.o_wr_data, 0);
    chk("rst_jump", bus.o_jump, 0);
    chk("rst_new_pc", bus.o_new_pc, 0);
    chk("rst_mem_valid", bus.o_mem_valid, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    chk("rst_mem_data", bus.o_mem_data, 0);
    chk("rst_mem_size", bus.o_mem_size, 0);
    chk("rst_sb_count", bus.o_sb_count, 0);
    chk("rst_sb_empty", bus.o_sb_empty, 1);
    chk("rst_ready", bus.o_ready, 1);
    rstn = 1'b1;

    // 16 jumps walk the tag 0..15 and wrap it back to 0.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, i, 0, 0, 0, 32'h1000 + 32'(16 * i), 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0,  1, 3, 32'hBEEF, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 15, 1, 4, 32'h4444, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  1, 5, 32'h1234, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3,  1, 6, 32'h9999, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  0, 0, 0, 32'h80, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0,  1, 7, 32'h7777, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  1, 8, 32'h55, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1,  1, 1, 32'h44, 32'h200, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 2,  1, 9, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5,  0, 0, 32'hEE, 32'h300, 0, 1, 2, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 2, 0, 0, 32'hA0 + 32'(i), 32'h100 + 32'(4 * i), 0, 1, i % 3, 0, 0, 1));
    tbl.push_back(mk(1, 2,  0, 0, 32'hA4, 32'h110, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2,  1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);
    idle();

    bus.i_mem_ready = 1'b1;
    for (int k = 0; k < 20 && cnt_m != 0; k++) idle();
    chk("drain_left", sq.size(), 0);
    chk("drain_empty", bus.o_sb_empty, 1);
    chk("drain_ready", bus.o_ready, 1);

    // Push and pop in the same cycle at count 2, then a stalled head.
    bus.i_mem_ready = 1'b0;
    apply(mk(1, 2, 0, 0, 32'hB0, 32'h200, 0, 1, 2, 0, 0, 1));
    apply(mk(1, 2, 0, 0, 32'hB1, 32'h204, 0, 1, 1, 0, 0, 1));
    bus.i_mem_ready = 1'b1;
    apply(mk(1, 2, 0, 0, 32'hB2, 32'h208, 0, 1, 0, 0, 0, 1));
    chk("pushpop_count", bus.o_sb_count, 2);
    bus.i_mem_ready = 1'b0;
    idle();
    idle();
    chk("head_stable", bus.o_mem_data, 32'hB1);

    // Reset with three stores pending.
    apply(mk(1, 2, 0, 0, 32'hB3, 32'h20C, 0, 1, 2, 0, 0, 1));
    rstn = 1'b0;
    #1;
    chk("midrst_mem_valid", bus.o_mem_valid, 0);
    chk("midrst_sb_count", bus.o_sb_count, 0);
    chk("midrst_sb_empty", bus.o_sb_empty, 1);
    chk("midrst_ready", bus.o_ready, 1);
    sq.delete();
    rq.delete();
    cnt_m = 0;
    pc_m = '0;
    @(negedge clk);
    rstn = 1'b1;
    apply(mk(1, 0, 1, 9, 32'hCAFE, 0, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 2, 1, 10, 32'hF00D, 0, 0, 0, 0, 0, 0, 0));
    idle();
    chk("rq_leftover", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
